// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and helpers for the fetch-stage program-counter unit.
//   pc_state_e  : FSM state (run, hold with pending redirect, halt)
//   redir_src_e : winning redirect source reported by the arbiter
//   align_mask  : mask that clears the low alignment bits of a target
package pc_unit_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHold = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SrcNone   = 2'd0,
    SrcFlush  = 2'd1,
    SrcBranch = 2'd2,
    SrcJump   = 2'd3
  } redir_src_e;

  // 32-bit mask with the low 'bits' bits cleared; callers slice to their width.
  function automatic logic [31:0] align_mask(input int unsigned bits);
    if (bits >= 32) begin
      return 32'd0;
    end
    return ~((32'd1 << bits) - 32'd1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the pipeline control and pc_unit.
//   Requests  : stall, flush/branch/jump enables and targets, halt_req, resume
//   Responses : pc_out, pc_plus_step, fetch_valid, halted
//   master    : pipeline side (drives requests)
//   slave     : pc_unit side (drives responses)
interface pc_unit_if #(
  parameter int unsigned PC_WIDTH = 11
);

  logic                stall;
  logic                flush_en;
  logic [PC_WIDTH-1:0] flush_target;
  logic                branch_en;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump_en;
  logic [PC_WIDTH-1:0] jump_target;
  logic                halt_req;
  logic                resume;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PC_WIDTH-1:0] pc_plus_step;
  logic                fetch_valid;
  logic                halted;

  modport master (
    output stall, flush_en, flush_target, branch_en, branch_target,
           jump_en, jump_target, halt_req, resume,
    input  pc_out, pc_plus_step, fetch_valid, halted
  );

  modport slave (
    input  stall, flush_en, flush_target, branch_en, branch_target,
           jump_en, jump_target, halt_req, resume,
    output pc_out, pc_plus_step, fetch_valid, halted
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational priority select among redirect requests.
//   Priority flush > branch > jump. The chosen target has its low ALIGN_BITS cleared.
//   Inputs : flush_en/target, branch_en/target, jump_en/target
//   Outputs: src (winning source, SrcNone if no request), target (aligned)
module pc_redirect_arb
  import pc_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 11,
  parameter int unsigned ALIGN_BITS = 0
) (
  input  logic                flush_en,
  input  logic [PC_WIDTH-1:0] flush_target,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_target,
  output redir_src_e          src,
  output logic [PC_WIDTH-1:0] target
);

  localparam logic [31:0]         MaskFull = align_mask(ALIGN_BITS);
  localparam logic [PC_WIDTH-1:0] Mask     = MaskFull[PC_WIDTH-1:0];

  logic [PC_WIDTH-1:0] raw_target;

  always_comb begin
    src        = SrcNone;
    raw_target = '0;
    if (flush_en) begin
      src        = SrcFlush;
      raw_target = flush_target;
    end else if (branch_en) begin
      src        = SrcBranch;
      raw_target = branch_target;
    end else if (jump_en) begin
      src        = SrcJump;
      raw_target = jump_target;
    end
  end

  assign target = raw_target & Mask;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter for the fetch stage.
//   clock : rising-edge clock
//   reset : synchronous, active-high; loads RESET_VECTOR, returns to run
//   bus   : pc_unit_if slave modport (stall, redirects, halt/resume in;
//           pc_out, pc_plus_step, fetch_valid, halted out)
// A branch/jump seen while stalled is parked in pend_q (state hold) and
// applied on the first unstalled cycle; flush always takes effect at once.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 11,
  parameter int unsigned          PC_STEP      = 1,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input logic       clock,
  input logic       reset,
  pc_unit_if.slave  bus
);

  localparam int unsigned         ALIGN_BITS = $clog2(PC_STEP);
  localparam logic [PC_WIDTH-1:0] Step       = PC_WIDTH'(PC_STEP);

  pc_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;

  redir_src_e          redir_src;
  logic [PC_WIDTH-1:0] redir_target;

  pc_redirect_arb #(
    .PC_WIDTH   (PC_WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_arb (
    .flush_en      (bus.flush_en),
    .flush_target  (bus.flush_target),
    .branch_en     (bus.branch_en),
    .branch_target (bus.branch_target),
    .jump_en       (bus.jump_en),
    .jump_target   (bus.jump_target),
    .src           (redir_src),
    .target        (redir_target)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      StRun: begin
        if (!bus.stall) begin
          if (redir_src != SrcNone) begin
            pc_d = redir_target;
          end else if (bus.halt_req) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + Step;
          end
        end else if (redir_src == SrcFlush) begin
          pc_d = redir_target;
        end else if (redir_src != SrcNone) begin
          pend_d  = redir_target;
          state_d = StHold;
        end
      end
      StHold: begin
        if (redir_src == SrcFlush) begin
          pc_d    = redir_target;
          pend_d  = '0;
          state_d = StRun;
        end else if (bus.stall) begin
          // Latest branch/jump replaces the parked one.
          if (redir_src != SrcNone) begin
            pend_d = redir_target;
          end
        end else begin
          // Parked redirect wins over anything new; halt_req is dropped here.
          pc_d    = pend_q;
          pend_d  = '0;
          state_d = StRun;
        end
      end
      StHalt: begin
        if (redir_src == SrcFlush) begin
          pc_d    = redir_target;
          state_d = StRun;
        end else if (bus.resume) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus_step = pc_q + Step;
  assign bus.fetch_valid  = !reset && (state_q == StRun) && !bus.stall;
  assign bus.halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
//   dut1: PC_WIDTH=11, PC_STEP=1, RESET_VECTOR=0 (directed table + random vs model)
//   dut2: PC_WIDTH=11, PC_STEP=4, RESET_VECTOR=0x100 (alignment, reset-in-hold, wrap)
module tb_pc_unit;

  logic clk;
  logic rst1;
  logic rst2;
  int   n_checks;
  int   n_fail;

  pc_unit_if #(.PC_WIDTH(11)) bus1 ();
  pc_unit_if #(.PC_WIDTH(11)) bus2 ();

  pc_unit #(
    .PC_WIDTH     (11),
    .PC_STEP      (1),
    .RESET_VECTOR (11'h000)
  ) dut1 (
    .clock (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  pc_unit #(
    .PC_WIDTH     (11),
    .PC_STEP      (4),
    .RESET_VECTOR (11'h100)
  ) dut2 (
    .clock (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit rst;
    bit stall;
    bit fl;
    int fl_t;
    bit br;
    int br_t;
    bit jp;
    int jp_t;
    bit hr;
    bit rs;
    int exp_pc;
    bit exp_fv;
    bit exp_h;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit stall, bit fl, int fl_t, bit br, int br_t,
                             bit jp, int jp_t, bit hr, bit rs, int pc, bit fv, bit h);
    vec_t r;
    r.rst = rst; r.stall = stall; r.fl = fl; r.fl_t = fl_t; r.br = br; r.br_t = br_t;
    r.jp = jp; r.jp_t = jp_t; r.hr = hr; r.rs = rs;
    r.exp_pc = pc; r.exp_fv = fv; r.exp_h = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive1(input bit rst, input bit stall, input bit fl, input int fl_t,
                        input bit br, input int br_t, input bit jp, input int jp_t,
                        input bit hr, input bit rs);
    rst1               = rst;
    bus1.stall         = stall;
    bus1.flush_en      = fl;
    bus1.flush_target  = 11'(fl_t);
    bus1.branch_en     = br;
    bus1.branch_target = 11'(br_t);
    bus1.jump_en       = jp;
    bus1.jump_target   = 11'(jp_t);
    bus1.halt_req      = hr;
    bus1.resume        = rs;
  endtask

  task automatic drive2(input bit rst, input bit stall, input bit br, input int br_t,
                        input bit jp, input int jp_t);
    rst2               = rst;
    bus2.stall         = stall;
    bus2.flush_en      = 1'b0;
    bus2.flush_target  = '0;
    bus2.branch_en     = br;
    bus2.branch_target = 11'(br_t);
    bus2.jump_en       = jp;
    bus2.jump_target   = 11'(jp_t);
    bus2.halt_req      = 1'b0;
    bus2.resume        = 1'b0;
  endtask

  // Reference model for dut1: mode 0=running, 1=redirect parked, 2=halted.
  localparam int MStep = 1;
  localparam int MMod  = 2048;
  int m_pc, m_mode, m_pend;

  task automatic model_step(input bit rst, input bit stall, input bit fl, input int fl_t,
                            input bit br, input int br_t, input bit jp, input int jp_t,
                            input bit hr, input bit rs);
    int  tgt;
    bit  any;
    any = fl || br || jp;
    tgt = fl ? fl_t : (br ? br_t : jp_t);
    tgt = tgt - (tgt % MStep);
    if (rst) begin
      m_pc = 0; m_mode = 0; m_pend = 0;
      return;
    end
    if (m_mode == 2) begin
      if (fl) begin m_pc = tgt; m_mode = 0; end
      else if (rs) m_mode = 0;
    end else if (m_mode == 1) begin
      if (fl) begin m_pc = tgt; m_mode = 0; m_pend = 0; end
      else if (!stall) begin m_pc = m_pend; m_mode = 0; end
      else if (any) m_pend = tgt;
    end else begin
      if (stall) begin
        if (fl) m_pc = tgt;
        else if (any) begin m_pend = tgt; m_mode = 1; end
      end else if (any) m_pc = tgt;
      else if (hr) m_mode = 2;
      else m_pc = (m_pc + MStep) % MMod;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive1(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive2(1, 0, 0, 0, 0, 0);

    //      rst st fl flt   br brt   jp jpt   hr rs  pc    fv h
    tbl.push_back(v(1, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h000, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h000, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h000, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h001, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h002, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h003, 1, 0));
    // Wrap-around.
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     1, 'h7FE, 0, 0, 'h004, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h7FE, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h7FF, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h000, 1, 0));
    // Branch under stall parked, applied when stall drops.
    tbl.push_back(v(0, 1, 0, 0,     1, 'h100, 0, 0,     0, 0, 'h001, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h001, 0, 0));
    // Priority.
    tbl.push_back(v(0, 0, 1, 'h40,  1, 'h80,  1, 'hC0,  0, 0, 'h100, 1, 0));
    tbl.push_back(v(0, 0, 0, 'h40,  1, 'h80,  1, 'hC0,  0, 0, 'h040, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     1, 'h10,  0, 0, 'h080, 1, 0));
    // Halt at 0x10, ignores branch/stall, resume.
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     1, 0, 'h010, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     1, 'h300, 0, 0,     0, 0, 'h010, 0, 1));
    tbl.push_back(v(0, 1, 0, 0,     1, 'h300, 0, 0,     0, 0, 'h010, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,     1, 'h300, 0, 0,     0, 0, 'h010, 0, 1));
    tbl.push_back(v(0, 1, 0, 0,     1, 'h300, 0, 0,     0, 0, 'h010, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,     1, 'h300, 0, 0,     0, 0, 'h010, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 1, 'h010, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h010, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h011, 1, 0));
    // halt_req beats resume; flush beats resume in halt.
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     1, 1, 'h012, 1, 0));
    tbl.push_back(v(0, 0, 1, 'h55,  0, 0,     0, 0,     0, 1, 'h012, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h055, 1, 0));
    // Latest parked redirect wins; unstall applies it over new branch and halt_req.
    tbl.push_back(v(0, 1, 0, 0,     1, 'h200, 0, 0,     0, 0, 'h056, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,     1, 'h210, 0, 0, 'h056, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     1, 'h300, 0, 0,     1, 0, 'h056, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h210, 1, 0));
    // Reset while parked discards pending.
    tbl.push_back(v(0, 1, 0, 0,     1, 'h200, 0, 0,     0, 0, 'h211, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h211, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h000, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h001, 1, 0));
    // Flush under stall applies at once; flush while parked.
    tbl.push_back(v(0, 1, 1, 'h77,  0, 0,     0, 0,     0, 0, 'h002, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,     0, 0,     0, 0,     0, 0, 'h077, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h077, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,     1, 'h20,  0, 0,     0, 0, 'h078, 0, 0));
    tbl.push_back(v(0, 1, 1, 'h30,  0, 0,     0, 0,     0, 0, 'h078, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     0, 0,     0, 0,     0, 0, 'h030, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive1(tbl[i].rst, tbl[i].stall, tbl[i].fl, tbl[i].fl_t, tbl[i].br, tbl[i].br_t,
             tbl[i].jp, tbl[i].jp_t, tbl[i].hr, tbl[i].rs);
      #1;
      check($sformatf("tbl%0d pc_out", i), 32'(bus1.pc_out), 32'(tbl[i].exp_pc));
      check($sformatf("tbl%0d fetch_valid", i), 32'(bus1.fetch_valid), 32'(tbl[i].exp_fv));
      check($sformatf("tbl%0d halted", i), 32'(bus1.halted), 32'(tbl[i].exp_h));
      check($sformatf("tbl%0d pc_plus_step", i), 32'(bus1.pc_plus_step),
            32'((tbl[i].exp_pc + 1) % 2048));
    end

    // dut2: PC_STEP=4, RESET_VECTOR=0x100.
    @(negedge clk); drive2(1, 0, 0, 0, 0, 0); #1;
    check("d2 reset pc", 32'(bus2.pc_out), 32'h100);
    check("d2 reset fv", 32'(bus2.fetch_valid), 32'd0);
    @(negedge clk); drive2(0, 0, 0, 0, 0, 0); #1;
    check("d2 first pc", 32'(bus2.pc_out), 32'h100);
    check("d2 first fv", 32'(bus2.fetch_valid), 32'd1);
    check("d2 first pps", 32'(bus2.pc_plus_step), 32'h104);
    @(negedge clk); drive2(0, 0, 0, 0, 1, 'h13); #1;
    check("d2 seq pc", 32'(bus2.pc_out), 32'h104);
    @(negedge clk); drive2(0, 0, 0, 0, 0, 0); #1;
    check("d2 aligned jump", 32'(bus2.pc_out), 32'h010);
    @(negedge clk); drive2(0, 1, 1, 'h203, 0, 0); #1;
    check("d2 stall pc", 32'(bus2.pc_out), 32'h014);
    check("d2 stall fv", 32'(bus2.fetch_valid), 32'd0);
    @(negedge clk); drive2(1, 0, 0, 0, 0, 0); #1;
    check("d2 rst in hold fv", 32'(bus2.fetch_valid), 32'd0);
    @(negedge clk); drive2(0, 0, 0, 0, 0, 0); #1;
    check("d2 after rst pc", 32'(bus2.pc_out), 32'h100);
    check("d2 after rst fv", 32'(bus2.fetch_valid), 32'd1);
    @(negedge clk); drive2(0, 0, 0, 0, 1, 'h7FE); #1;
    check("d2 no pending", 32'(bus2.pc_out), 32'h104);
    @(negedge clk); drive2(0, 0, 0, 0, 0, 0); #1;
    check("d2 wrap pc", 32'(bus2.pc_out), 32'h7FC);
    check("d2 wrap pps", 32'(bus2.pc_plus_step), 32'h000);
    @(negedge clk); #1;
    check("d2 wrapped", 32'(bus2.pc_out), 32'h000);

    // Random stimulus on dut1 against the model; first cycle is a forced reset.
    for (int n = 0; n < 3000; n++) begin
      bit rst, st, fl, br, jp, hr, rs;
      int flt, brt, jpt;
      rst = (n == 0) || ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 4) == 0);
      jp  = ($urandom_range(0, 4) == 0);
      hr  = ($urandom_range(0, 11) == 0);
      rs  = ($urandom_range(0, 3) == 0);
      flt = $urandom_range(0, 2047);
      brt = $urandom_range(0, 2047);
      jpt = $urandom_range(0, 2047);
      @(negedge clk);
      drive1(rst, st, fl, flt, br, brt, jp, jpt, hr, rs);
      #1;
      if (n == 0) begin
        check("rnd init fv", 32'(bus1.fetch_valid), 32'd0);
      end else begin
        check($sformatf("rnd%0d pc_out", n), 32'(bus1.pc_out), 32'(m_pc));
        check($sformatf("rnd%0d pc_plus_step", n), 32'(bus1.pc_plus_step),
              32'((m_pc + MStep) % MMod));
        check($sformatf("rnd%0d fetch_valid", n), 32'(bus1.fetch_valid),
              32'(!rst && m_mode == 0 && !st));
        check($sformatf("rnd%0d halted", n), 32'(bus1.halted), 32'(m_mode == 2));
      end
      model_step(rst, st, fl, flt, br, brt, jp, jpt, hr, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
